// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : stage payload structs and derived widths for pipe_stage_reg
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [1:0]  mem2reg;
        logic [3:0]  dram_we;
        logic        rf_we;
        logic        j_type;
        logic [31:0] rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
    } id_ex_t;

    // dram_we is a per-byte write enable, which brings the struct to 136 bits
    typedef struct packed {
        logic [1:0]  mem2reg;
        logic [3:0]  dram_we;
        logic        rf_we;
        logic        j_type;
        logic [31:0] rd;
        logic [31:0] result;
        logic [31:0] rd2;
        logic [31:0] pc;
    } ex_mem_t;

    typedef struct packed {
        logic [1:0]  mem2reg;
        logic        rf_we;
        logic [31:0] rd;
        logic [31:0] result;
        logic [31:0] rdata;
        logic [31:0] pc;
    } mem_wb_t;

    localparam int IF_ID_W     = $bits(if_id_t);
    localparam int ID_EX_W     = $bits(id_ex_t);
    localparam int EX_MEM_W    = $bits(ex_mem_t);
    localparam int MEM_WB_W    = $bits(mem_wb_t);
    localparam int STALL_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : valid/ready pipeline register with optional skid entry,
//                  flush, occupancy and saturating stall counter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = EX_MEM_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              w_s_valid;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_xfer = in_valid && w_in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_s_valid;
            logic [DATA_W-1:0] r_s_data;

            // in_ready comes straight from a flop, breaking the ready chain
            assign w_s_valid  = r_s_valid;
            assign w_in_ready = !r_s_valid;

            always_ff @(posedge clk) begin
                if (!reset || flush) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                    r_s_valid <= 1'b0;
                    r_s_data  <= '0;
                end else if (!r_m_valid) begin
                    if (w_in_xfer) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= in_data;
                    end
                end else if (out_ready) begin
                    if (r_s_valid) begin
                        r_m_data  <= r_s_data;
                        r_s_valid <= 1'b0;
                        r_s_data  <= '0;
                    end else if (w_in_xfer) begin
                        r_m_data  <= in_data;
                    end else begin
                        r_m_valid <= 1'b0;
                        r_m_data  <= '0;
                    end
                end else if (w_in_xfer) begin
                    r_s_valid <= 1'b1;
                    r_s_data  <= in_data;
                end
            end
        end else begin : g_noskid
            assign w_s_valid  = 1'b0;
            assign w_in_ready = !r_m_valid || out_ready;

            always_ff @(posedge clk) begin
                if (!reset || flush) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                end else if (w_in_xfer) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= in_data;
                end else if (r_m_valid && out_ready) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                end
            end
        end
    endgenerate

    // Flush leaves the counter alone so debug sees total stall history
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_m_valid;
    assign out_data  = r_m_data;
    assign occupancy = {r_m_valid & w_s_valid, r_m_valid ^ w_s_valid};
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : scoreboard bench for a SKID=1 and a SKID=0 instance
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DW = 136;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          ir [2];
    logic          ov [2];
    logic [DW-1:0] od [2];
    logic [1:0]    occ [2];
    logic [15:0]   sc_a;
    logic [3:0]    sc_b;
    logic [15:0]   sc [2];

    int n_checks = 0;
    int n_err    = 0;
    bit armed    = 1'b0;

    // Reference: each stage is a FIFO of accepted beats plus a stall tally
    logic [DW-1:0] mq [2][$];
    int            mst [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]), .stall_cnt(sc_a)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(4)) u_dut_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]), .stall_cnt(sc_b)
    );

    assign sc[0] = sc_a;
    assign sc[1] = {12'd0, sc_b};

    task automatic chk(input string nm, input int k,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    // Monitor: compare against the reference, then advance it by the
    // inputs that the coming posedge will sample.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int unsigned n;
            bit          rdy;
            int          smax;
            n    = mq[k].size();
            rdy  = (k == 0) ? (n < 2) : ((n == 0) || out_ready);
            smax = (k == 0) ? 65535 : 15;
            if (armed) begin
                chk("out_valid", k, DW'(ov[k]), DW'(n > 0));
                chk("occupancy", k, DW'(occ[k]), DW'(n));
                chk("in_ready", k, DW'(ir[k]), DW'(rdy));
                chk("stall_cnt", k, DW'(sc[k]), DW'(mst[k]));
                if (n > 0) begin
                    if (out_ready) chk("out_beat", k, od[k], mq[k][0]);
                    else           chk("held_head", k, od[k], mq[k][0]);
                end else begin
                    chk("bubble_data", k, od[k], '0);
                end
            end
            if (!reset) begin
                mq[k].delete();
                mst[k] = 0;
            end else begin
                if ((n > 0) && !out_ready && (mst[k] < smax)) mst[k]++;
                if (flush) begin
                    mq[k].delete();
                end else begin
                    if ((n > 0) && out_ready) void'(mq[k].pop_front());
                    if (in_valid && rdy) mq[k].push_back(in_data);
                end
            end
        end
        if (!reset) armed = 1'b1;
    end

    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit ordy,
                       input bit fl, input bit rst_n);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst_n;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    endfunction

    initial begin
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 1, 0, 1);

        // Streaming 0x1..0x8
        for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 1, 0, 1);
        cyc(0, '0, 1, 0, 1);

        // Backpressure: A, B with out_ready low, then drain
        cyc(1, DW'(8'hAA), 0, 0, 1);
        cyc(1, DW'(8'hBB), 0, 0, 1);
        cyc(1, DW'(8'hCC), 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);

        // Flush with a beat offered
        cyc(1, DW'(8'h11), 0, 0, 1);
        cyc(1, DW'(8'h22), 0, 0, 1);
        cyc(1, DW'(8'h33), 0, 1, 1);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);

        // Reset mid-stream with both entries full
        cyc(1, DW'(8'h44), 0, 0, 1);
        cyc(1, DW'(8'h55), 0, 0, 1);
        cyc(1, DW'(8'h66), 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 1, 0, 1);

        // Stall saturation (4-bit counter on the SKID=0 instance)
        cyc(1, DW'(8'h77), 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, '0, 0, 0, 1);

        // SKID=0 pass-through: ready with a held M releases same cycle
        cyc(1, DW'(4'h5), 1, 0, 1);
        cyc(0, '0, 1, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 2) != 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
        end
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
